// File: rtl/rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: FSM states, instruction field
// layout, opcode/funct constants and the ALU select codes.
package rtype_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int OP_W      = 6;
  localparam int REG_W     = 5;
  localparam int SHAMT_W   = 5;
  localparam int FUNCT_W   = 6;

  localparam logic [OP_W-1:0] RTYPE_OPCODE = 6'b000000;

  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;

  // Shifts share one select; the shifter takes its direction from funct.
  localparam logic [2:0] ALU_SHIFT = 3'd0;
  localparam logic [2:0] ALU_AND   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_NOR   = 3'd3;
  localparam logic [2:0] ALU_ADD   = 3'd4;
  localparam logic [2:0] ALU_SUB   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;

  localparam int EXEC_CNT_W = 4;

  function automatic logic is_legal_rtype(input logic [OP_W-1:0]    op,
                                          input logic [FUNCT_W-1:0] funct);
    logic funct_ok;
    case (funct)
      FN_AND, FN_OR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_SLTU, FN_SRA, FN_SRL, FN_SLL, FN_NOR: funct_ok = 1'b1;
      default:                                 funct_ok = 1'b0;
    endcase
    return (op == RTYPE_OPCODE) && funct_ok;
  endfunction

endpackage

// File: rtl/rtype_sequencer_control_unit.sv
// ALU control unit: maps an R-type funct code onto the 3-bit ALU select.
// Unknown codes fall back to the shift select (funct 0 also selects shift).
module rtype_sequencer_control_unit
  import rtype_sequencer_pkg::*;
(
  output logic [2:0]         select_bits_ALU,
  input  logic [FUNCT_W-1:0] alu_funct
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    select_bits_ALU = ALU_SHIFT;
    case (alu_funct)
      FN_AND:           select_bits_ALU = ALU_AND;
      FN_OR:            select_bits_ALU = ALU_OR;
      FN_NOR:           select_bits_ALU = ALU_NOR;
      FN_ADD, FN_ADDU:  select_bits_ALU = ALU_ADD;
      FN_SUB, FN_SUBU:  select_bits_ALU = ALU_SUB;
      FN_SLTU:          select_bits_ALU = ALU_SLTU;
      default:          select_bits_ALU = ALU_SHIFT;
    endcase
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: handshake-in, DECODE, EXEC (EXEC_CYCLES long),
// then WB or ERR, with registered control outputs and a retired counter.
module rtype_sequencer
  import rtype_sequencer_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [REG_W-1:0]   rf_rs_addr,
  output logic [REG_W-1:0]   rf_rt_addr,
  output logic [REG_W-1:0]   rf_rd_addr,
  output logic               rf_we,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic               alu_en,
  output logic [2:0]         select_bits_ALU,
  output logic               done,
  output logic               illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   retired_count
);

  localparam logic [EXEC_CNT_W-1:0] EXEC_INIT = EXEC_CNT_W'(EXEC_CYCLES - 1);

  state_e                state_q;
  logic [31:0]           ir_q;
  logic [EXEC_CNT_W-1:0] exec_cnt_q;
  logic                  ready_q;
  logic                  rf_we_q;
  logic                  alu_en_q;
  logic                  done_q;
  logic                  illegal_q;
  logic [CNT_W-1:0]      retired_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      exec_cnt_q <= '0;
      ready_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here; every flop samples pre-edge values.
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && instr_valid) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal_rtype(ir_q[OP_LSB +: OP_W], ir_q[FUNCT_LSB +: FUNCT_W])) begin
            exec_cnt_q <= EXEC_INIT;
            alu_en_q   <= 1'b1;
            state_q    <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_ERR;
          end
        end
        S_EXEC: begin
          if (exec_cnt_q == '0) begin
            alu_en_q  <= 1'b0;
            rf_we_q   <= (ir_q[RD_LSB +: REG_W] != '0);
            done_q    <= 1'b1;
            retired_q <= retired_q + CNT_W'(1);
            state_q   <= S_WB;
          end else begin
            exec_cnt_q <= exec_cnt_q - EXEC_CNT_W'(1);
          end
        end
        S_WB, S_ERR: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Field outputs come straight from IR, so they hold their last value in IDLE.
  assign rf_rs_addr    = ir_q[RS_LSB +: REG_W];
  assign rf_rt_addr    = ir_q[RT_LSB +: REG_W];
  assign rf_rd_addr    = ir_q[RD_LSB +: REG_W];
  assign alu_funct     = ir_q[FUNCT_LSB +: FUNCT_W];
  assign alu_shamt     = ir_q[SHAMT_LSB +: SHAMT_W];
  assign instr_ready   = ready_q;
  assign rf_we         = rf_we_q;
  assign alu_en        = alu_en_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign retired_count = retired_q;
  assign busy          = (state_q != S_IDLE);

  rtype_sequencer_control_unit u_control_unit (
    .select_bits_ALU (select_bits_ALU),
    .alu_funct       (alu_funct)
  );

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench for rtype_sequencer: directed scenarios plus random
// instruction streams, compared every cycle against a transaction-timeline model.
module tb_rtype_sequencer;

  localparam int E  = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [4:0]    rf_rs_addr, rf_rt_addr, rf_rd_addr;
  logic          rf_we;
  logic [5:0]    alu_funct;
  logic [4:0]    alu_shamt;
  logic          alu_en;
  logic [2:0]    select_bits_ALU;
  logic          done, illegal, busy;
  logic [CW-1:0] retired_count;

  rtype_sequencer #(.EXEC_CYCLES(E), .CNT_W(CW)) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .rf_rs_addr      (rf_rs_addr),
    .rf_rt_addr      (rf_rt_addr),
    .rf_rd_addr      (rf_rd_addr),
    .rf_we           (rf_we),
    .alu_funct       (alu_funct),
    .alu_shamt       (alu_shamt),
    .alu_en          (alu_en),
    .select_bits_ALU (select_bits_ALU),
    .done            (done),
    .illegal         (illegal),
    .busy            (busy),
    .retired_count   (retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one transaction at a time, tracked by its cycle offset from the handshake.
  bit          m_active;
  int          m_off;
  logic [31:0] m_ir;
  bit          m_ready;
  int          m_count;
  bit          m_hs;

  int legal_codes[11] = '{36, 37, 32, 33, 34, 35, 43, 3, 2, 0, 39};
  logic [31:0] stim[$];

  function automatic bit legal_ref(input logic [31:0] w);
    if (w[31:26] != 6'd0) return 1'b0;
    foreach (legal_codes[i]) if (int'(w[5:0]) == legal_codes[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] sel_ref(input logic [5:0] f);
    case (int'(f))
      36:      return 3'd1;
      37:      return 3'd2;
      39:      return 3'd3;
      32, 33:  return 3'd4;
      34, 35:  return 3'd5;
      43:      return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_off    = 0;
    m_ir     = '0;
    m_ready  = 1'b0;
    m_count  = 0;
    m_hs     = 1'b0;
  endtask

  task automatic model_edge();
    bit lg;
    m_hs = 1'b0;
    if (m_active) begin
      lg = legal_ref(m_ir);
      m_off++;
      if (lg && m_off == 2 + E) m_count = (m_count + 1) % (1 << CW);
      if (m_off == (lg ? 3 + E : 3)) begin
        m_active = 1'b0;
        m_ready  = 1'b1;
      end
    end else if (m_ready && instr_valid) begin
      m_active = 1'b1;
      m_off    = 1;
      m_ir     = instr;
      m_ready  = 1'b0;
      m_hs     = 1'b1;
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic check_all();
    bit lg, e_alu, e_done, e_ill;
    lg     = legal_ref(m_ir);
    e_alu  = m_active && lg && m_off >= 2 && m_off <= 1 + E;
    e_done = m_active && lg && m_off == 2 + E;
    e_ill  = m_active && !lg && m_off == 2;
    check("instr_ready", instr_ready, m_ready);
    check("busy", busy, m_active);
    check("alu_en", alu_en, e_alu);
    check("done", done, e_done);
    check("rf_we", rf_we, e_done && (m_ir[15:11] != 5'd0));
    check("illegal", illegal, e_ill);
    check("retired_count", retired_count, m_count);
    check("rf_rs_addr", rf_rs_addr, m_ir[25:21]);
    check("rf_rt_addr", rf_rt_addr, m_ir[20:16]);
    check("rf_rd_addr", rf_rd_addr, m_ir[15:11]);
    check("alu_funct", alu_funct, m_ir[5:0]);
    check("alu_shamt", alu_shamt, m_ir[10:6]);
    check("select_bits_ALU", select_bits_ALU, sel_ref(m_ir[5:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted away from the clock edge, held across two edges.
  task automatic apply_reset();
    instr_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic run_stream(input int gap_pct, input bit check_spacing);
    int budget, n, exp_alu, alu_hi;
    int hs_cycles[$];
    n       = stim.size();
    budget  = 40 * (n + 1);
    exp_alu = 0;
    alu_hi  = 0;
    foreach (stim[i]) if (legal_ref(stim[i])) exp_alu += E;
    while ((stim.size() > 0 || m_active) && budget > 0) begin
      if (stim.size() > 0 && $urandom_range(99) >= gap_pct) begin
        instr_valid = 1'b1;
        instr       = stim[0];
      end else begin
        instr_valid = 1'b0;
        instr       = $urandom;
      end
      if (instr_ready && instr_valid) hs_cycles.push_back(cyc);
      tick();
      if (alu_en) alu_hi++;
      if (m_hs) void'(stim.pop_front());
      budget--;
    end
    instr_valid = 1'b0;
    check("stream_in_budget", budget > 0, 1'b1);
    check("handshake_count", hs_cycles.size(), n);
    check("alu_en_cycles", alu_hi, exp_alu);
    if (check_spacing)
      for (int i = 1; i < hs_cycles.size(); i++)
        check("handshake_spacing", hs_cycles[i] - hs_cycles[i-1], 3 + E);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, funct;
    logic [4:0] rd;
    op    = ($urandom_range(9) == 0) ? 6'($urandom_range(63, 1)) : 6'd0;
    funct = ($urandom_range(4) != 0) ? 6'(legal_codes[$urandom_range(10)]) : 6'($urandom);
    rd    = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
    return {op, 5'($urandom), 5'($urandom), rd, 5'($urandom), funct};
  endfunction

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    model_reset();
    apply_reset();

    // ADD rd=8 rs=9 rt=10, offered while instr_ready is still low after reset.
    stim = {32'h012A4020};
    run_stream(0, 0);
    check("add_retired", retired_count, 1);

    // Non-zero opcode, then opcode 0 with an unsupported funct (001000).
    stim = {32'h05294020, 32'h03E00008};
    run_stream(0, 0);
    check("illegal_no_count", retired_count, 1);

    // rd == 0: retires without a register write.
    stim = {32'h01290024};
    run_stream(0, 0);
    check("rd0_retired", retired_count, 2);

    // Back-to-back with valid held high, then a fourth to wrap the 2-bit counter.
    apply_reset();
    stim = {32'h012A4020, 32'h00854822, 32'h00C73025};
    run_stream(0, 1);
    check("b2b_count", retired_count, 3);
    stim = {32'h014B6027};
    run_stream(0, 0);
    check("wrap_count", retired_count, 0);
    stim = {32'h012A4020};
    run_stream(0, 0);

    // Reset while in EXEC: aborts with no write and no retire.
    instr_valid = 1'b1;
    instr       = 32'h012A4020;
    for (int i = 0; i < 6 && !(m_active && m_off == 2); i++) tick();
    instr_valid = 1'b0;
    check("midexec_alu_en", alu_en, 1'b1);
    apply_reset();
    repeat (E + 3) tick();
    check("midexec_count", retired_count, 0);

    // Random stream with gaps in instr_valid.
    for (int i = 0; i < 40; i++) stim.push_back(rand_instr());
    run_stream(30, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
